control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired control unit that sits directly upstream of the ALU system datapath and drives every one of its control inputs. It fetches a 16-bit instruction into IR as two byte reads (low byte, then high byte) from memory at PC. It then decodes IROut and issues one or two execute microcycles. It replaces the test-vector driver as the source of datapath control.

## Interface
- No parameters.
- Clock  in  1  datapath clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high; sampled on the rising edge of Clock.
- IROut  in  16  IR contents. Fields: [15:12] opcode, [11:10] Rd, [9:8] Rs, [7:0] imm/addr.
- ALUOutFlag  in  4  {Z,C,N,O} from the ALU, valid combinationally in the same cycle.
- RF_OutASel, RF_OutBSel, RF_FunSel  out  2 each  register-file controls.
- RF_RegSel  out  4  one-hot write enable, R(k) = bit k, active-high.
- ALU_FunSel  out  4  ALU operation: 0000 pass A, 0100 A+B, 0101 A−B.
- ARF_OutCSel, ARF_OutDSel, ARF_FunSel  out  2 each  address-register-file controls. OutDSel: 00 PC, 01 AR.
- ARF_RegSel  out  3  write enables {PC,AR,SP}, active-high.
- IR_LH  out  1  IR byte select: 0 low, 1 high.
- IR_Enable  out  1  IR write enable.
- IR_Funsel  out  2  IR function select.
- Mem_WR  out  1  1 = write.
- Mem_CS  out  1  chip select, active-low.
- MuxASel  out  2  RF input: 00 ALUOut, 01 MemOut, 10 IR[7:0], 11 ARF COut.
- MuxBSel  out  2  ARF input, same encoding as MuxASel.
- MuxCSel  out  1  ALU A input: 0 RF AOut, 1 ARF COut.
- State  out  3  current state, for debug.
- Halted  out  1  high in HALT.

FunSel encoding, common to RF, ARF and IR: 00 clear, 01 load, 10 decrement, 11 increment.

## Operation
- States: INIT=0, FETCH_L=1, FETCH_H=2, EXEC1=3, EXEC2=4, HALT=5.
- Outputs are decoded combinationally from State, IROut and the internal Z latch.
- Idle default, applied to every output not listed for a state: all RegSel = 0, IR_Enable = 0, Mem_CS = 1, Mem_WR = 0, every other field = 0.
- INIT: RF_RegSel = 1111, ARF_RegSel = 111, IR_Enable = 1, all FunSels = 00 (clear). Next state FETCH_L.
- FETCH_L: Mem_CS = 0, ARF_OutDSel = 00, IR_Enable = 1, IR_LH = 0, IR_Funsel = 01, ARF_RegSel = 100, ARF_FunSel = 11 (PC++). Next state FETCH_H.
- FETCH_H: same as FETCH_L with IR_LH = 1. Next state EXEC1.
- EXEC1, by opcode:
  - 0 LDI: MuxASel = 10, RF_FunSel = 01, RF_RegSel = 1<<Rd. Next FETCH_L.
  - 1 LD and 2 ST: MuxBSel = 10, ARF_FunSel = 01, ARF_RegSel = 010 (AR←addr). Next EXEC2.
  - 3 ADD and 4 SUB: RF_OutASel = Rd, RF_OutBSel = Rs, MuxCSel = 0, ALU_FunSel = 0100 / 0101, MuxASel = 00, RF_FunSel = 01, RF_RegSel = 1<<Rd. Z latch ← ALUOutFlag[3] at the end of the cycle. Next FETCH_L.
  - 5 INC: RF_FunSel = 11, RF_RegSel = 1<<Rd. Next FETCH_L.
  - 6 BRA: MuxBSel = 10, ARF_FunSel = 01, ARF_RegSel = 100. Next FETCH_L.
  - 7 BNE: same as BRA when Z latch = 0; otherwise idle. Next FETCH_L.
  - F HLT: idle. Next HALT.
  - All other opcodes: idle (NOP). Next FETCH_L.
- EXEC2:
  - LD: ARF_OutDSel = 01, Mem_CS = 0, MuxASel = 01, RF_FunSel = 01, RF_RegSel = 1<<Rd.
  - ST: ARF_OutDSel = 01, RF_OutASel = Rd, MuxCSel = 0, ALU_FunSel = 0000, Mem_CS = 0, Mem_WR = 1.
  - Next FETCH_L.
- HALT: idle, Halted = 1. Stays in HALT until Reset.
- Z latch is written only by ADD and SUB; it is cleared on Reset.

## Timing
- Reset high at an edge: State ← INIT and Z ← 0 regardless of current state. This includes mid-instruction, EXEC2 with Mem_WR = 1, and HALT.
- While Reset is held, outputs are the INIT pattern. That pattern is the reset value of every output: RF_RegSel 1111, ARF_RegSel 111, IR_Enable 1, Mem_CS 1, all other outputs 0.
- Instruction latency, counted from entering FETCH_L:
  - 3 cycles: LDI, ADD, SUB, INC, BRA, BNE, NOP.
  - 4 cycles: LD, ST.
- PC points to the next instruction (old PC+2) by EXEC1; a branch overwrites it in EXEC1.
- IROut is stable from EXEC1 onward.
- Rd = Rs for ADD or SUB is legal: read and write occur in the same cycle, and the register updates at the edge.
- PC wraps 255→0 inside the ARF; the sequencer has no special handling for it.

## Test plan
- Reset held for 2 cycles, then released: INIT outputs hold while Reset is high. The next state sequence is FETCH_L, FETCH_H, EXEC1; the FETCH_L/H patterns match the spec and PC = 2 at EXEC1.
- LDI R2, 0x5A (IROut = 0x085A): in EXEC1, MuxASel = 10, RF_RegSel = 0100, RF_FunSel = 01; the following state is FETCH_L.
- SUB R0, R0 (ALUOutFlag[3] = 1), then BNE 0x40: ARF_RegSel stays 000 in the BNE EXEC1. Repeat with Z = 0: ARF_RegSel = 100, MuxBSel = 10.
- ST R1, 0x80 (IROut = 0x2480): EXEC1 loads AR. EXEC2 drives Mem_WR = 1, Mem_CS = 0, ARF_OutDSel = 01, RF_OutASel = 01, ALU_FunSel = 0000.
- LD R3, 0x10 with Reset asserted during EXEC2: the next state is INIT, Mem_CS = 1, and no RF write occurs after the edge.
- HLT (0xF000): State = 5 and Halted = 1 for 20 cycles; after a Reset pulse, State returns through INIT to FETCH_L.

Source files
------------

// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the ALU system datapath.
// The sequencer drives through the master modport. The datapath, or a bench
// standing in for it, connects through the slave modport.
interface control_sequencer_if;
   logic [15:0] IROut;
   logic [3:0]  ALUOutFlag;

   logic [1:0]  RF_OutASel;
   logic [1:0]  RF_OutBSel;
   logic [1:0]  RF_FunSel;
   logic [3:0]  RF_RegSel;
   logic [3:0]  ALU_FunSel;
   logic [1:0]  ARF_OutCSel;
   logic [1:0]  ARF_OutDSel;
   logic [1:0]  ARF_FunSel;
   logic [2:0]  ARF_RegSel;
   logic        IR_LH;
   logic        IR_Enable;
   logic [1:0]  IR_Funsel;
   logic        Mem_WR;
   logic        Mem_CS;
   logic [1:0]  MuxASel;
   logic [1:0]  MuxBSel;
   logic        MuxCSel;
   logic [2:0]  State;
   logic        Halted;

   modport master (
      input  IROut, ALUOutFlag,
      output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
             ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
             IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
             MuxASel, MuxBSel, MuxCSel, State, Halted
   );

   modport slave (
      output IROut, ALUOutFlag,
      input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, ALU_FunSel,
             ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
             IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS,
             MuxASel, MuxBSel, MuxCSel, State, Halted
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the ALU system datapath.
// Control outputs are decoded combinationally from the state, the IR fields and the Z latch.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   INIT    | clear RF, ARF and IR; held here while Reset is high
//   FETCH_L | read mem[PC] into IR low byte, PC++
//   FETCH_H | read mem[PC] into IR high byte, PC++
//   EXEC1   | first execute microcycle (all opcodes)
//   EXEC2   | memory microcycle for LD / ST
//   HALT    | idle until Reset
module control_sequencer (
   input  logic                       Clock,
   input  logic                       Reset,
   control_sequencer_if.master        bus
);

   typedef enum logic [2:0] {
      S_INIT    = 3'd0,
      S_FETCH_L = 3'd1,
      S_FETCH_H = 3'd2,
      S_EXEC1   = 3'd3,
      S_EXEC2   = 3'd4,
      S_HALT    = 3'd5
   } state_t;

   localparam logic [3:0] OP_LDI = 4'h0;
   localparam logic [3:0] OP_LD  = 4'h1;
   localparam logic [3:0] OP_ST  = 4'h2;
   localparam logic [3:0] OP_ADD = 4'h3;
   localparam logic [3:0] OP_SUB = 4'h4;
   localparam logic [3:0] OP_INC = 4'h5;
   localparam logic [3:0] OP_BRA = 4'h6;
   localparam logic [3:0] OP_BNE = 4'h7;
   localparam logic [3:0] OP_HLT = 4'hF;

   localparam logic [1:0] FUN_CLR  = 2'b00;
   localparam logic [1:0] FUN_LOAD = 2'b01;
   localparam logic [1:0] FUN_INC  = 2'b11;

   localparam logic [1:0] MUX_ALU = 2'b00;
   localparam logic [1:0] MUX_MEM = 2'b01;
   localparam logic [1:0] MUX_IMM = 2'b10;

   localparam logic [3:0] ALU_PASS_A = 4'b0000;
   localparam logic [3:0] ALU_ADD    = 4'b0100;
   localparam logic [3:0] ALU_SUB    = 4'b0101;

   state_t state_q, state_d;
   logic   z_q, z_d;

   logic [3:0] opcode;
   logic [1:0] rd;
   logic [1:0] rs;
   logic [3:0] rd_onehot;

   assign opcode    = bus.IROut[15:12];
   assign rd        = bus.IROut[11:10];
   assign rs        = bus.IROut[9:8];
   assign rd_onehot = 4'b0001 << rd;

   // The immediate byte goes straight to the datapath muxes; only Z is kept from the flags.
   logic unused_inputs;
   assign unused_inputs = ^{bus.IROut[7:0], bus.ALUOutFlag[2:0]};

   logic [1:0] rf_outa_sel, rf_outb_sel, rf_fun;
   logic [3:0] rf_regsel;
   logic [3:0] alu_fun;
   logic [1:0] arf_outc_sel, arf_outd_sel, arf_fun;
   logic [2:0] arf_regsel;
   logic       ir_lh, ir_en;
   logic [1:0] ir_fun;
   logic       mem_wr, mem_cs;
   logic [1:0] mux_a, mux_b;
   logic       mux_c;
   logic       halted;

   always_comb begin
      state_d = state_q;
      z_d     = z_q;
      case (state_q)
         S_INIT:    state_d = S_FETCH_L;
         S_FETCH_L: state_d = S_FETCH_H;
         S_FETCH_H: state_d = S_EXEC1;
         S_EXEC1: begin
            case (opcode)
               OP_LD, OP_ST: state_d = S_EXEC2;
               OP_HLT:       state_d = S_HALT;
               default:      state_d = S_FETCH_L;
            endcase
            if (opcode == OP_ADD || opcode == OP_SUB) begin
               z_d = bus.ALUOutFlag[3];
            end
         end
         S_EXEC2:   state_d = S_FETCH_L;
         S_HALT:    state_d = S_HALT;
         default:   state_d = S_INIT;
      endcase
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_INIT;
         z_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
      end
   end

   always_comb begin
      rf_outa_sel  = 2'b00;
      rf_outb_sel  = 2'b00;
      rf_fun       = FUN_CLR;
      rf_regsel    = 4'b0000;
      alu_fun      = ALU_PASS_A;
      arf_outc_sel = 2'b00;
      arf_outd_sel = 2'b00;
      arf_fun      = FUN_CLR;
      arf_regsel   = 3'b000;
      ir_lh        = 1'b0;
      ir_en        = 1'b0;
      ir_fun       = FUN_CLR;
      mem_wr       = 1'b0;
      mem_cs       = 1'b1;
      mux_a        = MUX_ALU;
      mux_b        = MUX_ALU;
      mux_c        = 1'b0;
      halted       = 1'b0;

      case (state_q)
         S_INIT: begin
            rf_regsel  = 4'b1111;
            arf_regsel = 3'b111;
            ir_en      = 1'b1;
         end

         S_FETCH_L, S_FETCH_H: begin
            mem_cs       = 1'b0;
            arf_outd_sel = 2'b00;
            ir_en        = 1'b1;
            ir_lh        = (state_q == S_FETCH_H);
            ir_fun       = FUN_LOAD;
            arf_regsel   = 3'b100;
            arf_fun      = FUN_INC;
         end

         S_EXEC1: begin
            case (opcode)
               OP_LDI: begin
                  mux_a     = MUX_IMM;
                  rf_fun    = FUN_LOAD;
                  rf_regsel = rd_onehot;
               end
               OP_LD, OP_ST: begin
                  mux_b      = MUX_IMM;
                  arf_fun    = FUN_LOAD;
                  arf_regsel = 3'b010;
               end
               OP_ADD, OP_SUB: begin
                  rf_outa_sel = rd;
                  rf_outb_sel = rs;
                  mux_c       = 1'b0;
                  alu_fun     = (opcode == OP_ADD) ? ALU_ADD : ALU_SUB;
                  mux_a       = MUX_ALU;
                  rf_fun      = FUN_LOAD;
                  rf_regsel   = rd_onehot;
               end
               OP_INC: begin
                  rf_fun    = FUN_INC;
                  rf_regsel = rd_onehot;
               end
               OP_BRA: begin
                  mux_b      = MUX_IMM;
                  arf_fun    = FUN_LOAD;
                  arf_regsel = 3'b100;
               end
               OP_BNE: begin
                  if (!z_q) begin
                     mux_b      = MUX_IMM;
                     arf_fun    = FUN_LOAD;
                     arf_regsel = 3'b100;
                  end
               end
               default: ;
            endcase
         end

         S_EXEC2: begin
            if (opcode == OP_LD) begin
               arf_outd_sel = 2'b01;
               mem_cs       = 1'b0;
               mux_a        = MUX_MEM;
               rf_fun       = FUN_LOAD;
               rf_regsel    = rd_onehot;
            end else if (opcode == OP_ST) begin
               // Rd passes through the ALU unchanged to reach the memory data input.
               arf_outd_sel = 2'b01;
               rf_outa_sel  = rd;
               mux_c        = 1'b0;
               alu_fun      = ALU_PASS_A;
               mem_cs       = 1'b0;
               mem_wr       = 1'b1;
            end
         end

         S_HALT: halted = 1'b1;

         default: ;
      endcase
   end

   assign bus.RF_OutASel  = rf_outa_sel;
   assign bus.RF_OutBSel  = rf_outb_sel;
   assign bus.RF_FunSel   = rf_fun;
   assign bus.RF_RegSel   = rf_regsel;
   assign bus.ALU_FunSel  = alu_fun;
   assign bus.ARF_OutCSel = arf_outc_sel;
   assign bus.ARF_OutDSel = arf_outd_sel;
   assign bus.ARF_FunSel  = arf_fun;
   assign bus.ARF_RegSel  = arf_regsel;
   assign bus.IR_LH       = ir_lh;
   assign bus.IR_Enable   = ir_en;
   assign bus.IR_Funsel   = ir_fun;
   assign bus.Mem_WR      = mem_wr;
   assign bus.Mem_CS      = mem_cs;
   assign bus.MuxASel     = mux_a;
   assign bus.MuxBSel     = mux_b;
   assign bus.MuxCSel     = mux_c;
   assign bus.State       = state_q;
   assign bus.Halted      = halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: drives IROut/ALUOutFlag and checks decoded controls,
// with a small PC/AR model that follows the ARF controls.
module tb_control_sequencer;
   logic Clock;
   logic Reset;
   int   tests;
   int   failed;

   control_sequencer_if cs ();

   control_sequencer dut (
      .Clock (Clock),
      .Reset (Reset),
      .bus   (cs.master)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Address register file model: PC and AR respond to the controls the sequencer issues.
   logic [7:0] pc_m;
   logic [7:0] ar_m;
   logic [7:0] arf_in;
   assign arf_in = (cs.MuxBSel == 2'b10) ? cs.IROut[7:0] : 8'h00;

   always @(posedge Clock) begin
      if (cs.ARF_RegSel[2]) begin
         case (cs.ARF_FunSel)
            2'b00: pc_m <= 8'h00;
            2'b01: pc_m <= arf_in;
            2'b10: pc_m <= pc_m - 8'd1;
            default: pc_m <= pc_m + 8'd1;
         endcase
      end
      if (cs.ARF_RegSel[1]) begin
         case (cs.ARF_FunSel)
            2'b00: ar_m <= 8'h00;
            2'b01: ar_m <= arf_in;
            2'b10: ar_m <= ar_m - 8'd1;
            default: ar_m <= ar_m + 8'd1;
         endcase
      end
   end

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // From FETCH_L: present the instruction and advance to EXEC1.
   task automatic fetch(input logic [15:0] ir);
      cs.IROut = ir;
      step();
      step();
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      step();
      step();
      tests++; if (cs.State !== 3'd0) begin failed++; $display("FAIL rst_state got=%0d exp=0", cs.State); end
      tests++; if (cs.RF_RegSel !== 4'b1111) begin failed++; $display("FAIL rst_rf_regsel got=%b exp=1111", cs.RF_RegSel); end
      tests++; if (cs.ARF_RegSel !== 3'b111) begin failed++; $display("FAIL rst_arf_regsel got=%b exp=111", cs.ARF_RegSel); end
      tests++; if ({cs.IR_Enable, cs.Mem_CS, cs.Mem_WR, cs.Halted} !== 4'b1100) begin failed++; $display("FAIL rst_ctl got=%b exp=1100", {cs.IR_Enable, cs.Mem_CS, cs.Mem_WR, cs.Halted}); end
      tests++; if ({cs.RF_FunSel, cs.ARF_FunSel, cs.IR_Funsel, cs.ALU_FunSel, cs.MuxASel, cs.MuxBSel} !== 16'h0000) begin failed++; $display("FAIL rst_fields got=%h exp=0000", {cs.RF_FunSel, cs.ARF_FunSel, cs.IR_Funsel, cs.ALU_FunSel, cs.MuxASel, cs.MuxBSel}); end
      Reset = 1'b0;
      tests++; if (cs.State !== 3'd0) begin failed++; $display("FAIL rst_hold_state got=%0d exp=0", cs.State); end
      cs.IROut = 16'hE000;
      step();
      tests++; if (cs.State !== 3'd1) begin failed++; $display("FAIL fl_state got=%0d exp=1", cs.State); end
      tests++; if ({cs.Mem_CS, cs.IR_Enable, cs.IR_LH, cs.IR_Funsel, cs.ARF_RegSel, cs.ARF_FunSel, cs.ARF_OutDSel} !== 12'b0_1_0_01_100_11_00) begin failed++; $display("FAIL fl_pattern got=%b exp=010011001100", {cs.Mem_CS, cs.IR_Enable, cs.IR_LH, cs.IR_Funsel, cs.ARF_RegSel, cs.ARF_FunSel, cs.ARF_OutDSel}); end
      step();
      tests++; if (cs.State !== 3'd2) begin failed++; $display("FAIL fh_state got=%0d exp=2", cs.State); end
      tests++; if ({cs.Mem_CS, cs.IR_Enable, cs.IR_LH, cs.IR_Funsel, cs.ARF_RegSel, cs.ARF_FunSel} !== 10'b0_1_1_01_100_11) begin failed++; $display("FAIL fh_pattern got=%b exp=0110110011", {cs.Mem_CS, cs.IR_Enable, cs.IR_LH, cs.IR_Funsel, cs.ARF_RegSel, cs.ARF_FunSel}); end
      step();
      tests++; if (cs.State !== 3'd3) begin failed++; $display("FAIL ex1_state got=%0d exp=3", cs.State); end
      tests++; if (pc_m !== 8'd2) begin failed++; $display("FAIL ex1_pc got=%0d exp=2", pc_m); end
      tests++; if ({cs.RF_RegSel, cs.ARF_RegSel, cs.Mem_CS} !== 8'b0000_000_1) begin failed++; $display("FAIL nop_idle got=%b exp=00000001", {cs.RF_RegSel, cs.ARF_RegSel, cs.Mem_CS}); end
      step();
      tests++; if (cs.State !== 3'd1) begin failed++; $display("FAIL nop_next got=%0d exp=1", cs.State); end
   endtask

   task automatic test_ldi();
      fetch(16'h085A);
      tests++; if (cs.MuxASel !== 2'b10) begin failed++; $display("FAIL ldi_muxa got=%b exp=10", cs.MuxASel); end
      tests++; if (cs.RF_RegSel !== 4'b0100) begin failed++; $display("FAIL ldi_regsel got=%b exp=0100", cs.RF_RegSel); end
      tests++; if (cs.RF_FunSel !== 2'b01) begin failed++; $display("FAIL ldi_funsel got=%b exp=01", cs.RF_FunSel); end
      tests++; if (cs.ARF_RegSel !== 3'b000) begin failed++; $display("FAIL ldi_arf got=%b exp=000", cs.ARF_RegSel); end
      step();
      tests++; if (cs.State !== 3'd1) begin failed++; $display("FAIL ldi_next got=%0d exp=1", cs.State); end
   endtask

   task automatic test_inc();
      fetch(16'h5800);
      tests++; if ({cs.RF_FunSel, cs.RF_RegSel} !== 6'b11_0100) begin failed++; $display("FAIL inc_ctl got=%b exp=110100", {cs.RF_FunSel, cs.RF_RegSel}); end
      step();
      tests++; if (cs.State !== 3'd1) begin failed++; $display("FAIL inc_next got=%0d exp=1", cs.State); end
   endtask

   task automatic test_bne();
      cs.ALUOutFlag = 4'b1000;
      fetch(16'h4000);
      tests++; if (cs.ALU_FunSel !== 4'b0101) begin failed++; $display("FAIL sub_alu got=%b exp=0101", cs.ALU_FunSel); end
      tests++; if ({cs.RF_RegSel, cs.RF_FunSel, cs.MuxASel, cs.RF_OutASel, cs.RF_OutBSel, cs.MuxCSel} !== 13'b0001_01_00_00_00_0) begin failed++; $display("FAIL sub_ctl got=%b exp=0001010000000", {cs.RF_RegSel, cs.RF_FunSel, cs.MuxASel, cs.RF_OutASel, cs.RF_OutBSel, cs.MuxCSel}); end
      step();
      cs.ALUOutFlag = 4'b0000;
      fetch(16'h7040);
      tests++; if (cs.ARF_RegSel !== 3'b000) begin failed++; $display("FAIL bne_taken_z1 got=%b exp=000", cs.ARF_RegSel); end
      step();
      tests++; if (pc_m !== 8'd10) begin failed++; $display("FAIL bne_z1_pc got=%0d exp=10", pc_m); end
      fetch(16'h3600);
      tests++; if ({cs.ALU_FunSel, cs.RF_OutASel, cs.RF_OutBSel, cs.RF_RegSel} !== 12'b0100_01_10_0010) begin failed++; $display("FAIL add_ctl got=%b exp=010001100010", {cs.ALU_FunSel, cs.RF_OutASel, cs.RF_OutBSel, cs.RF_RegSel}); end
      step();
      fetch(16'h7040);
      tests++; if ({cs.ARF_RegSel, cs.MuxBSel, cs.ARF_FunSel} !== 7'b100_10_01) begin failed++; $display("FAIL bne_z0 got=%b exp=1001001", {cs.ARF_RegSel, cs.MuxBSel, cs.ARF_FunSel}); end
      step();
      tests++; if (pc_m !== 8'h40) begin failed++; $display("FAIL bne_z0_pc got=%h exp=40", pc_m); end
   endtask

   task automatic test_st();
      fetch(16'h2480);
      tests++; if ({cs.MuxBSel, cs.ARF_FunSel, cs.ARF_RegSel} !== 7'b10_01_010) begin failed++; $display("FAIL st_ex1 got=%b exp=1001010", {cs.MuxBSel, cs.ARF_FunSel, cs.ARF_RegSel}); end
      step();
      tests++; if (cs.State !== 3'd4) begin failed++; $display("FAIL st_ex2_state got=%0d exp=4", cs.State); end
      tests++; if (ar_m !== 8'h80) begin failed++; $display("FAIL st_ar got=%h exp=80", ar_m); end
      tests++; if ({cs.Mem_WR, cs.Mem_CS, cs.ARF_OutDSel, cs.RF_OutASel, cs.ALU_FunSel, cs.MuxCSel, cs.RF_RegSel} !== 15'b1_0_01_01_0000_0_0000) begin failed++; $display("FAIL st_ex2 got=%b exp=101010000000000", {cs.Mem_WR, cs.Mem_CS, cs.ARF_OutDSel, cs.RF_OutASel, cs.ALU_FunSel, cs.MuxCSel, cs.RF_RegSel}); end
      step();
      tests++; if (cs.State !== 3'd1) begin failed++; $display("FAIL st_next got=%0d exp=1", cs.State); end
   endtask

   task automatic test_ld_reset();
      fetch(16'h1C10);
      step();
      tests++; if ({cs.State, cs.RF_RegSel, cs.MuxASel, cs.RF_FunSel, cs.Mem_CS, cs.ARF_OutDSel, cs.Mem_WR} !== 15'b100_1000_01_01_0_01_0) begin failed++; $display("FAIL ld_ex2 got=%b exp=100100001010010", {cs.State, cs.RF_RegSel, cs.MuxASel, cs.RF_FunSel, cs.Mem_CS, cs.ARF_OutDSel, cs.Mem_WR}); end
      Reset = 1'b1;
      step();
      tests++; if (cs.State !== 3'd0) begin failed++; $display("FAIL ld_rst_state got=%0d exp=0", cs.State); end
      tests++; if ({cs.Mem_CS, cs.Mem_WR, cs.RF_FunSel, cs.MuxASel} !== 6'b10_00_00) begin failed++; $display("FAIL ld_rst_ctl got=%b exp=100000", {cs.Mem_CS, cs.Mem_WR, cs.RF_FunSel, cs.MuxASel}); end
      Reset = 1'b0;
      step();
      tests++; if (cs.State !== 3'd1) begin failed++; $display("FAIL ld_rst_next got=%0d exp=1", cs.State); end
   endtask

   task automatic test_z_reset();
      cs.ALUOutFlag = 4'b1000;
      fetch(16'h4500);
      step();
      cs.ALUOutFlag = 4'b0000;
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      step();
      fetch(16'h7020);
      tests++; if (cs.ARF_RegSel !== 3'b100) begin failed++; $display("FAIL z_cleared_bne got=%b exp=100", cs.ARF_RegSel); end
      step();
      tests++; if (pc_m !== 8'h20) begin failed++; $display("FAIL z_cleared_pc got=%h exp=20", pc_m); end
   endtask

   task automatic test_halt();
      fetch(16'hF000);
      tests++; if ({cs.RF_RegSel, cs.ARF_RegSel, cs.Mem_CS, cs.IR_Enable} !== 9'b0000_000_1_0) begin failed++; $display("FAIL hlt_ex1 got=%b exp=000000010", {cs.RF_RegSel, cs.ARF_RegSel, cs.Mem_CS, cs.IR_Enable}); end
      for (int i = 0; i < 20; i++) begin
         step();
         tests++; if ({cs.State, cs.Halted, cs.Mem_CS} !== 5'b101_1_1) begin failed++; $display("FAIL halt_cycle%0d got=%b exp=10111", i, {cs.State, cs.Halted, cs.Mem_CS}); end
      end
      Reset = 1'b1;
      step();
      tests++; if ({cs.State, cs.Halted} !== 4'b000_0) begin failed++; $display("FAIL halt_rst got=%b exp=0000", {cs.State, cs.Halted}); end
      Reset = 1'b0;
      step();
      tests++; if (cs.State !== 3'd1) begin failed++; $display("FAIL halt_rst_next got=%0d exp=1", cs.State); end
   endtask

   initial begin
      tests         = 0;
      failed        = 0;
      Reset         = 1'b1;
      cs.IROut      = 16'hE000;
      cs.ALUOutFlag = 4'b0000;
      test_reset();
      test_ldi();
      test_inc();
      test_bne();
      test_st();
      test_ld_reset();
      test_z_reset();
      test_halt();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
